// File: rtl/deserializer8_pkg.sv
// Shared definitions for the shifter8 serial path: word/counter widths and
// the receive FSM state encoding.
package deserializer8_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : deserializer8_pkg

// File: rtl/deser_out_reg.sv
// One-entry valid/ready holding register for completed words; drops a new
// word and raises a sticky overrun when the entry is full and not being popped.
module deser_out_reg
  import deserializer8_pkg::*;
#(
  parameter int unsigned DATA_W = deserializer8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              pop_c;

  // A pop frees the entry in the same cycle, so a simultaneous commit is accepted.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    pop_c     = valid_q && ready_i;
    if (commit_i) begin
      if (!valid_q || pop_c) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pop_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule : deser_out_reg

// File: rtl/deserializer8.sv
// Serial-in / parallel-out receiver for the shifter8 path: frames bits on
// s_sof, assembles MSB- or LSB-first, and hands words to a valid/ready register.
module deserializer8
  import deserializer8_pkg::*;
#(
  parameter int unsigned DATA_W = deserializer8_pkg::DATA_W,
  parameter int unsigned CNT_W  = deserializer8_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              msb_first,
  input  logic              s_valid,
  input  logic              s_bit,
  input  logic              s_sof,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              overrun,
  output logic              frame_err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              msb_q, msb_d;
  logic              ferr_q, ferr_d;
  logic              commit_c;
  logic              last_c;
  logic [DATA_W-1:0] first_c;
  logic [DATA_W-1:0] shift_c;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    ferr_d   = ferr_q;
    commit_c = 1'b0;
    last_c   = (cnt_q == CNT_W'(DATA_W - 1));
    // A fresh word starts from an empty register so no stale bits linger.
    first_c  = msb_first ? {{(DATA_W-1){1'b0}}, s_bit} : {s_bit, {(DATA_W-1){1'b0}}};
    shift_c  = msb_q ? {sr_q[DATA_W-2:0], s_bit} : {s_bit, sr_q[DATA_W-1:1]};
    if (s_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (s_sof) begin
            sr_d    = first_c;
            msb_d   = msb_first;
            cnt_d   = CNT_W'(1);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // s_sof on the final bit is data; anywhere earlier it truncates the word.
          if (s_sof && !last_c) begin
            ferr_d = 1'b1;
            sr_d   = first_c;
            msb_d  = msb_first;
            cnt_d  = CNT_W'(1);
          end else begin
            sr_d  = shift_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_c) begin
              commit_c = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      ferr_q  <= ferr_d;
    end
  end

  deser_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .commit_i  (commit_c),
    .word_i    (sr_d),
    .ready_i   (d_ready),
    .data_o    (d_out),
    .valid_o   (d_valid),
    .overrun_o (overrun)
  );

  assign bit_cnt   = cnt_q;
  assign frame_err = ferr_q;

endmodule : deserializer8

// File: tb/tb_deserializer8.sv
// Self-checking bench for deserializer8: directed scenarios plus random
// traffic, all compared each cycle against a bit-queue reference model.
module tb_deserializer8;

  logic       clk;
  logic       reset, clr, msb_first, s_valid, s_bit, s_sof, d_ready;
  logic [7:0] d_out;
  logic       d_valid, overrun, frame_err;
  logic [2:0] bit_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit   m_bits[$];
  bit   m_in;
  bit   m_msb;
  int   m_dout;
  bit   m_dvalid, m_ovr, m_ferr;

  deserializer8 dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .msb_first (msb_first),
    .s_valid   (s_valid),
    .s_bit     (s_bit),
    .s_sof     (s_sof),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int assemble();
    int w = 0;
    for (int i = 0; i < 8; i++)
      if (m_bits[i]) w += m_msb ? (1 << (7 - i)) : (1 << i);
    return w;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit pop, commit;
    int word;
    pop    = m_dvalid && d_ready;
    commit = 0;
    word   = 0;
    if (reset || clr) begin
      m_bits.delete(); m_in = 0; m_dout = 0; m_dvalid = 0; m_ovr = 0; m_ferr = 0;
      return;
    end
    if (s_valid) begin
      if (s_sof && !(m_in && m_bits.size() == 7)) begin
        if (m_in) m_ferr = 1;
        m_bits.delete();
        m_bits.push_back(s_bit);
        m_msb = msb_first;
        m_in  = 1;
      end else if (m_in) begin
        m_bits.push_back(s_bit);
        if (m_bits.size() == 8) begin
          word   = assemble();
          commit = 1;
          m_bits.delete();
          m_in   = 0;
        end
      end
    end
    if (commit) begin
      if (!m_dvalid || pop) begin m_dout = word; m_dvalid = 1; end
      else m_ovr = 1;
    end else if (pop) m_dvalid = 0;
  endtask

  task automatic cycle(input logic rst, input logic cl, input logic msb, input logic sv,
                       input logic sb, input logic sof, input logic rdy);
    reset = rst; clr = cl; msb_first = msb; s_valid = sv; s_bit = sb; s_sof = sof; d_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("d_out",     int'(d_out),     m_dout);
    chk("d_valid",   int'(d_valid),   int'(m_dvalid));
    chk("bit_cnt",   int'(bit_cnt),   m_bits.size());
    chk("overrun",   int'(overrun),   int'(m_ovr));
    chk("frame_err", int'(frame_err), int'(m_ferr));
  endtask

  // Send a full word with s_sof on the first beat and `gap` idle cycles after each beat.
  task automatic send_word(input logic [7:0] w, input logic msb, input int gap, input logic rdy,
                           input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cycle(1'b0, 1'b0, msb, 1'b1, msb ? w[7-i] : w[i], i == 0, rdy);
      for (int g = 0; g < gap; g++)
        cycle(1'b0, 1'b0, logic'($urandom_range(1)), 1'b0, logic'($urandom_range(1)),
              logic'($urandom_range(1)), rdy);
    end
  endtask

  initial begin
    m_in = 0; m_msb = 0; m_dout = 0; m_dvalid = 0; m_ovr = 0; m_ferr = 0;
    reset = 1; clr = 0; msb_first = 0; s_valid = 0; s_bit = 0; s_sof = 0; d_ready = 0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("rst_dout", int'(d_out), 0);
    chk("rst_valid", int'(d_valid), 0);

    // 1: MSB-first back-to-back, 8'h77
    send_word(8'h77, 1, 0, 0, 8);
    chk("t1_dout", int'(d_out), 'h77);
    chk("t1_valid", int'(d_valid), 1);
    chk("t1_cnt", int'(bit_cnt), 0);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // 2: LSB-first with 2-cycle gaps, 8'h87
    send_word(8'h87, 0, 2, 0, 8);
    chk("t2_dout", int'(d_out), 'h87);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // 3: full output register forces an overrun
    send_word(8'h77, 1, 0, 0, 8);
    send_word(8'h87, 0, 0, 0, 8);
    chk("t3_dout", int'(d_out), 'h77);
    chk("t3_ovr", int'(overrun), 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pop", int'(d_valid), 0);

    // 4: pop and commit in the same cycle
    cycle(0, 1, 0, 0, 0, 0, 0);
    send_word(8'h5A, 1, 0, 0, 8);
    send_word(8'hC3, 1, 0, 0, 7);
    cycle(0, 0, 1, 1, 1, 0, 1);
    chk("t4_valid", int'(d_valid), 1);
    chk("t4_dout", int'(d_out), 'hC3);
    chk("t4_ovr", int'(overrun), 0);

    // 5: truncated word raises frame_err, then clr
    send_word(8'hFF, 1, 0, 1, 3);
    send_word(8'hA5, 1, 0, 1, 8);
    chk("t5_ferr", int'(frame_err), 1);
    chk("t5_dout", int'(d_out), 'hA5);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("t5_clr_ferr", int'(frame_err), 0);
    chk("t5_clr_valid", int'(d_valid), 0);

    // 6: reset mid-word, then a clean frame
    send_word(8'hE7, 0, 0, 0, 5);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("t6_cnt", int'(bit_cnt), 0);
    send_word(8'h3C, 0, 1, 0, 8);
    chk("t6_dout", int'(d_out), 'h3C);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle(logic'($urandom_range(63) == 0), logic'($urandom_range(63) == 0),
            logic'($urandom_range(1)), logic'($urandom_range(9) < 7),
            logic'($urandom_range(1)), logic'($urandom_range(15) == 0),
            logic'($urandom_range(1)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_deserializer8
